// File: rtl/mem_stage_sb.sv
// MEM pipeline stage: store buffer in front of a req/ack data memory port.
// Stores retire into the buffer and drain when the port is idle; loads own the port and wait on hazards.
module mem_stage_sb #(
  parameter int unsigned SB_DEPTH = 4,
  parameter int unsigned PTR_W    = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               Op_Valid_IN,
  input  logic [5:0]         ALU_Control_IN,
  input  logic [31:0]        ALU_result_IN,
  input  logic [31:0]        MemWriteData_IN,
  input  logic               MemRead_IN,
  input  logic               MemWrite_IN,
  input  logic [4:0]         WriteRegister_IN,
  input  logic               RegWrite_IN,
  input  logic               Drain_IN,
  output logic               Stall_OUT,
  output logic [4:0]         WriteRegister_OUT,
  output logic               RegWrite_OUT,
  output logic [31:0]        WriteData_OUT,
  output logic               dm_req,
  output logic               dm_we,
  output logic [31:0]        dm_addr,
  output logic [31:0]        dm_wdata,
  output logic [1:0]         dm_size,
  input  logic               dm_ack,
  input  logic [31:0]        dm_rdata,
  output logic [PTR_W:0]     Sb_Count_OUT
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [5:0] OP_LW  = 6'b111101;
  localparam logic [5:0] OP_LB  = 6'b100001;
  localparam logic [5:0] OP_LBU = 6'b101010;
  localparam logic [5:0] OP_LH  = 6'b101011;
  localparam logic [5:0] OP_LHU = 6'b101100;
  localparam logic [5:0] OP_SB  = 6'b101111;
  localparam logic [5:0] OP_SH  = 6'b110000;

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, DRAIN_WAIT} state_t;

  state_t               state;
  logic [31:0]          sb_addr  [SB_DEPTH];
  logic [31:0]          sb_data  [SB_DEPTH];
  logic [1:0]           sb_size  [SB_DEPTH];
  logic [SB_DEPTH-1:0]  sb_valid;
  logic [PTR_W-1:0]     head, tail;
  logic [CNT_W-1:0]     sb_count;

  logic        is_load, is_store, hazard, sb_empty, sb_full, fence;
  logic        load_go, issue_load, issue_drain, load_done, pop, retire, enq;
  logic [31:0] st_wdata, load_data;
  logic [1:0]  st_size;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic        half_ok;

  assign Sb_Count_OUT = sb_count;

  // Hazard: any buffered store to the same word as the presented address
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++)
      if (sb_valid[i] && (sb_addr[i][31:2] == ALU_result_IN[31:2])) hazard = 1'b1;
  end

  assign is_load     = Op_Valid_IN & MemRead_IN;
  assign is_store    = Op_Valid_IN & MemWrite_IN;
  assign sb_empty    = (sb_count == '0);
  assign sb_full     = (sb_count == CNT_W'(SB_DEPTH));
  assign fence       = Drain_IN & ~sb_empty;
  assign load_go     = is_load & ~is_store & ~hazard & ~fence;
  assign issue_load  = (state == IDLE) & load_go;
  // A blocked load must not block the drain, otherwise hazards/fences would deadlock
  assign issue_drain = (state == IDLE) & ~sb_empty & ~load_go;
  assign load_done   = (state == LOAD_WAIT) & dm_ack;
  assign pop         = (state == DRAIN_WAIT) & dm_ack;

  always_comb begin
    Stall_OUT = 1'b0;
    if ((is_load | is_store) & fence) Stall_OUT = 1'b1;
    else if (is_store)                Stall_OUT = sb_full;
    else if (is_load)                 Stall_OUT = ~load_done;
  end

  assign retire = Op_Valid_IN & ~Stall_OUT;
  assign enq    = retire & is_store;

  always_comb begin
    st_wdata = MemWriteData_IN;
    st_size  = 2'd0;
    if (ALU_Control_IN == OP_SB) begin
      st_wdata = {24'h0, MemWriteData_IN[7:0]};
      st_size  = 2'd1;
    end else if (ALU_Control_IN == OP_SH) begin
      st_wdata = {16'h0, MemWriteData_IN[15:0]};
      st_size  = 2'd2;
    end
  end

  // Big-endian extraction: byte 0 lives in [31:24]
  always_comb begin
    rd_byte = 8'h0;
    case (ALU_result_IN[1:0])
      2'd0:    rd_byte = dm_rdata[31:24];
      2'd1:    rd_byte = dm_rdata[23:16];
      2'd2:    rd_byte = dm_rdata[15:8];
      default: rd_byte = dm_rdata[7:0];
    endcase
    half_ok = ~ALU_result_IN[0];
    rd_half = ALU_result_IN[1] ? dm_rdata[15:0] : dm_rdata[31:16];
    load_data = dm_rdata;
    case (ALU_Control_IN)
      OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_data = {24'h0, rd_byte};
      OP_LH:   load_data = half_ok ? {{16{rd_half[15]}}, rd_half} : 32'h0;
      OP_LHU:  load_data = half_ok ? {16'h0, rd_half} : 32'h0;
      OP_LW:   load_data = dm_rdata;
      default: load_data = dm_rdata;
    endcase
  end

  // DM port FSM
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      dm_size  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_load) begin
            state    <= LOAD_WAIT;
            dm_req   <= 1'b1;
            dm_we    <= 1'b0;
            dm_addr  <= {ALU_result_IN[31:2], 2'b00};
            dm_wdata <= '0;
            dm_size  <= 2'd0;
          end else if (issue_drain) begin
            state    <= DRAIN_WAIT;
            dm_req   <= 1'b1;
            dm_we    <= 1'b1;
            dm_addr  <= sb_addr[head];
            dm_wdata <= sb_data[head];
            dm_size  <= sb_size[head];
          end
        end
        LOAD_WAIT, DRAIN_WAIT: begin
          if (dm_ack) begin
            state  <= IDLE;
            dm_req <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          dm_req <= 1'b0;
        end
      endcase
    end
  end

  // Store buffer FIFO
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head     <= '0;
      tail     <= '0;
      sb_count <= '0;
      sb_valid <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr[i] <= '0;
        sb_data[i] <= '0;
        sb_size[i] <= '0;
      end
    end else begin
      if (enq) begin
        sb_addr[tail]  <= ALU_result_IN;
        sb_data[tail]  <= st_wdata;
        sb_size[tail]  <= st_size;
        sb_valid[tail] <= 1'b1;
        tail           <= tail + PTR_W'(1);
      end
      if (pop) begin
        sb_valid[head] <= 1'b0;
        head           <= head + PTR_W'(1);
      end
      case ({enq, pop})
        2'b10:   sb_count <= sb_count + CNT_W'(1);
        2'b01:   sb_count <= sb_count - CNT_W'(1);
        default: sb_count <= sb_count;
      endcase
    end
  end

  // Writeback register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      WriteRegister_OUT <= '0;
      RegWrite_OUT      <= 1'b0;
      WriteData_OUT     <= '0;
    end else if (retire) begin
      WriteRegister_OUT <= WriteRegister_IN;
      RegWrite_OUT      <= RegWrite_IN & ~MemWrite_IN;
      WriteData_OUT     <= (is_load & load_done) ? load_data : ALU_result_IN;
    end else begin
      RegWrite_OUT      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_sb.sv
// Directed bench for mem_stage_sb: vector table for single ops and loads, hand sequences for
// store-buffer draining, fences, load priority and reset.
module tb_mem_stage_sb;

  logic        CLK, RESET;
  logic        Op_Valid_IN, MemRead_IN, MemWrite_IN, RegWrite_IN, Drain_IN;
  logic [5:0]  ALU_Control_IN;
  logic [31:0] ALU_result_IN, MemWriteData_IN;
  logic [4:0]  WriteRegister_IN;
  logic        Stall_OUT, RegWrite_OUT;
  logic [4:0]  WriteRegister_OUT;
  logic [31:0] WriteData_OUT;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [1:0]  dm_size;
  logic [2:0]  Sb_Count_OUT;

  localparam logic [5:0] NOP = 6'b000000, LW = 6'b111101, LB = 6'b100001, LBU = 6'b101010,
                         LH = 6'b101011, LHU = 6'b101100, SB = 6'b101111, SH = 6'b110000,
                         SW = 6'b110001;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  mem_stage_sb #(.SB_DEPTH(4), .PTR_W(2)) dut (
    .CLK(CLK), .RESET(RESET), .Op_Valid_IN(Op_Valid_IN), .ALU_Control_IN(ALU_Control_IN),
    .ALU_result_IN(ALU_result_IN), .MemWriteData_IN(MemWriteData_IN), .MemRead_IN(MemRead_IN),
    .MemWrite_IN(MemWrite_IN), .WriteRegister_IN(WriteRegister_IN), .RegWrite_IN(RegWrite_IN),
    .Drain_IN(Drain_IN), .Stall_OUT(Stall_OUT), .WriteRegister_OUT(WriteRegister_OUT),
    .RegWrite_OUT(RegWrite_OUT), .WriteData_OUT(WriteData_OUT), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_size(dm_size), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .Sb_Count_OUT(Sb_Count_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        valid;
    logic [5:0]  op;
    logic        mr;
    logic        mw;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        rw;
    logic [4:0]  rd;
    logic        chk_wd;
    logic [31:0] exp_wd;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic valid, input logic [5:0] op, input logic mr,
                               input logic mw, input logic [31:0] addr, input logic [31:0] rdata,
                               input logic rw, input logic [4:0] rd, input logic chk_wd,
                               input logic [31:0] exp_wd, input logic exp_rw);
    vec_t v;
    v.valid = valid; v.op = op; v.mr = mr; v.mw = mw; v.addr = addr; v.rdata = rdata;
    v.rw = rw; v.rd = rd; v.chk_wd = chk_wd; v.exp_wd = exp_wd; v.exp_rw = exp_rw;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drv(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                     input logic mr, input logic mw, input logic rw, input logic [4:0] rd,
                     input logic drn);
    Op_Valid_IN = 1'b1; ALU_Control_IN = op; ALU_result_IN = addr; MemWriteData_IN = data;
    MemRead_IN = mr; MemWrite_IN = mw; RegWrite_IN = rw; WriteRegister_IN = rd; Drain_IN = drn;
  endtask

  task automatic idle_in();
    Op_Valid_IN = 1'b0; MemRead_IN = 1'b0; MemWrite_IN = 1'b0; RegWrite_IN = 1'b0;
    Drain_IN = 1'b0; ALU_Control_IN = NOP;
  endtask

  // Acks every drain request, checking addresses against exp_q in FIFO order
  task automatic drain_all(input string name);
    int cyc = 0;
    logic [31:0] e;
    dm_ack = 1'b1;
    while (cyc < 60 && (Sb_Count_OUT != 3'd0 || dm_req)) begin
      if (dm_req && dm_we) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        chk({name, " drain addr"}, dm_addr, e);
      end
      @(negedge CLK); cyc++;
    end
    dm_ack = 1'b0;
    chk({name, " drained count"}, 32'(Sb_Count_OUT), 32'd0);
    chk({name, " drains left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_single(input vec_t v, input int idx);
    string n;
    n = $sformatf("vec%0d", idx);
    @(negedge CLK);
    drv(v.op, v.addr, 32'h0BAD_F00D, v.mr, v.mw, v.rw, v.rd, 1'b0);
    Op_Valid_IN = v.valid;
    #1 chk({n, " stall"}, 32'(Stall_OUT), 32'd0);
    @(negedge CLK);
    chk({n, " regwrite"}, 32'(RegWrite_OUT), 32'(v.exp_rw));
    if (v.chk_wd) begin
      chk({n, " wdata"}, WriteData_OUT, v.exp_wd);
      chk({n, " wreg"}, 32'(WriteRegister_OUT), 32'(v.rd));
    end
    chk({n, " count"}, 32'(Sb_Count_OUT), 32'd0);
    chk({n, " no req"}, 32'(dm_req), 32'd0);
    idle_in();
  endtask

  task automatic run_load(input vec_t v, input int idx);
    string n;
    n = $sformatf("vec%0d", idx);
    @(negedge CLK);
    drv(v.op, v.addr, 32'h0, 1'b1, 1'b0, v.rw, v.rd, 1'b0);
    #1 chk({n, " issue stall"}, 32'(Stall_OUT), 32'd1);
    @(negedge CLK);
    chk({n, " req"}, 32'(dm_req), 32'd1);
    chk({n, " we"}, 32'(dm_we), 32'd0);
    chk({n, " addr"}, dm_addr, {v.addr[31:2], 2'b00});
    dm_ack = 1'b1; dm_rdata = v.rdata;
    #1 chk({n, " ack stall"}, 32'(Stall_OUT), 32'd0);
    @(negedge CLK);
    chk({n, " wdata"}, WriteData_OUT, v.exp_wd);
    chk({n, " regwrite"}, 32'(RegWrite_OUT), 32'(v.exp_rw));
    chk({n, " req drop"}, 32'(dm_req), 32'd0);
    idle_in();
    dm_ack = 1'b0;
  endtask

  initial begin
    RESET = 1'b0; dm_ack = 1'b0; dm_rdata = '0; ALU_result_IN = '0; MemWriteData_IN = '0;
    WriteRegister_IN = '0;
    idle_in();

    vecs.push_back(mkv(1, NOP, 0, 0, 32'h1234_5678, 0, 1, 5'd3,  1, 32'h1234_5678, 1));
    vecs.push_back(mkv(1, NOP, 0, 0, 32'hFFFF_0000, 0, 0, 5'd31, 1, 32'hFFFF_0000, 0));
    vecs.push_back(mkv(0, SW,  0, 1, 32'h0000_0040, 0, 1, 5'd4,  0, 32'h0, 0));
    vecs.push_back(mkv(0, LW,  1, 0, 32'h0000_0044, 0, 1, 5'd5,  0, 32'h0, 0));
    vecs.push_back(mkv(1, LH,  1, 0, 32'h300, 32'h8001_7FFF, 1, 5'd7, 1, 32'hFFFF_8001, 1));
    vecs.push_back(mkv(1, LHU, 1, 0, 32'h302, 32'h8001_7FFF, 1, 5'd7, 1, 32'h0000_7FFF, 1));
    vecs.push_back(mkv(1, LBU, 1, 0, 32'h301, 32'h8001_7FFF, 1, 5'd7, 1, 32'h0000_0001, 1));
    vecs.push_back(mkv(1, LB,  1, 0, 32'h300, 32'h8001_7FFF, 1, 5'd8, 1, 32'hFFFF_FF80, 1));
    vecs.push_back(mkv(1, LB,  1, 0, 32'h302, 32'h8001_7FFF, 1, 5'd8, 1, 32'h0000_007F, 1));
    vecs.push_back(mkv(1, LBU, 1, 0, 32'h303, 32'h8001_7FFF, 1, 5'd9, 1, 32'h0000_00FF, 1));
    vecs.push_back(mkv(1, LH,  1, 0, 32'h301, 32'h8001_7FFF, 1, 5'd9, 1, 32'h0000_0000, 1));
    vecs.push_back(mkv(1, LHU, 1, 0, 32'h300, 32'h8001_7FFF, 1, 5'd9, 1, 32'h0000_8001, 1));
    vecs.push_back(mkv(1, LW,  1, 0, 32'h304, 32'h8001_7FFF, 1, 5'd10, 1, 32'h8001_7FFF, 1));

    // Reset state
    @(negedge CLK); @(negedge CLK);
    chk("rst dm_req", 32'(dm_req), 32'd0);
    chk("rst count", 32'(Sb_Count_OUT), 32'd0);
    chk("rst regwrite", 32'(RegWrite_OUT), 32'd0);
    chk("rst wdata", WriteData_OUT, 32'd0);
    RESET = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].valid && vecs[i].mr) run_load(vecs[i], i);
      else run_single(vecs[i], i);
    end

    // SW retires without stall, drains with raw address, ack after 3 cycles
    @(negedge CLK);
    drv(SW, 32'h100, 32'hDEAD_BEEF, 0, 1, 1, 5'd2, 0);
    #1 chk("sw stall", 32'(Stall_OUT), 32'd0);
    @(negedge CLK);
    chk("sw count", 32'(Sb_Count_OUT), 32'd1);
    chk("sw regwrite", 32'(RegWrite_OUT), 32'd0);
    chk("sw req early", 32'(dm_req), 32'd0);
    idle_in();
    @(negedge CLK);
    chk("sw req", 32'(dm_req), 32'd1);
    chk("sw we", 32'(dm_we), 32'd1);
    chk("sw addr", dm_addr, 32'h100);
    chk("sw size", 32'(dm_size), 32'd0);
    chk("sw data", dm_wdata, 32'hDEAD_BEEF);
    @(negedge CLK); @(negedge CLK);
    chk("sw req held", 32'(dm_req), 32'd1);
    dm_ack = 1'b1;
    @(negedge CLK);
    dm_ack = 1'b0;
    chk("sw count after ack", 32'(Sb_Count_OUT), 32'd0);
    chk("sw req after ack", 32'(dm_req), 32'd0);

    // Five back-to-back SB with ack held low: fifth stalls on full buffer
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      drv(SB, 32'h10 + 32'(i), 32'h1234_56A0 + 32'(i), 0, 1, 0, 5'd0, 0);
      #1 chk($sformatf("sb%0d stall", i), 32'(Stall_OUT), 32'd0);
    end
    @(negedge CLK);
    drv(SB, 32'h14, 32'h1234_56A4, 0, 1, 0, 5'd0, 0);
    #1 chk("sb4 stall", 32'(Stall_OUT), 32'd1);
    chk("sb4 count", 32'(Sb_Count_OUT), 32'd4);
    chk("sb head addr", dm_addr, 32'h10);
    chk("sb head wdata", dm_wdata, 32'h0000_00A0);
    chk("sb head size", 32'(dm_size), 32'd1);
    @(negedge CLK);
    dm_ack = 1'b1;
    #1 chk("sb4 stall on pop", 32'(Stall_OUT), 32'd1);
    @(negedge CLK);
    dm_ack = 1'b0;
    chk("sb after pop count", 32'(Sb_Count_OUT), 32'd3);
    chk("sb4 released", 32'(Stall_OUT), 32'd0);
    @(negedge CLK);
    chk("sb4 enq count", 32'(Sb_Count_OUT), 32'd4);
    idle_in();
    exp_q = '{32'h11, 32'h12, 32'h13, 32'h14};
    drain_all("sb fifo");

    // Load hazard on a buffered store to the same word
    @(negedge CLK);
    drv(SW, 32'h200, 32'h1122_3344, 0, 1, 0, 5'd0, 0);
    @(negedge CLK);
    drv(LB, 32'h203, 32'h0, 1, 0, 1, 5'd6, 0);
    #1 chk("hz stall", 32'(Stall_OUT), 32'd1);
    @(negedge CLK);
    chk("hz drain we", 32'(dm_we), 32'd1);
    chk("hz drain addr", dm_addr, 32'h200);
    chk("hz stall drain", 32'(Stall_OUT), 32'd1);
    @(negedge CLK);
    dm_ack = 1'b1;
    #1 chk("hz stall ack", 32'(Stall_OUT), 32'd1);
    @(negedge CLK);
    dm_ack = 1'b0;
    chk("hz count", 32'(Sb_Count_OUT), 32'd0);
    chk("hz stall issue", 32'(Stall_OUT), 32'd1);
    @(negedge CLK);
    chk("hz load req", 32'(dm_req), 32'd1);
    chk("hz load we", 32'(dm_we), 32'd0);
    chk("hz load addr", dm_addr, 32'h200);
    dm_ack = 1'b1; dm_rdata = 32'h1122_3344;
    #1 chk("hz load stall", 32'(Stall_OUT), 32'd0);
    @(negedge CLK);
    dm_ack = 1'b0;
    chk("hz wdata", WriteData_OUT, 32'h0000_0044);
    idle_in();

    // Non-hazard load takes priority over two buffered stores
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      drv(SW, 32'h500 + 32'(4 * i), 32'hA000_0000 + 32'(i), 0, 1, 0, 5'd0, 0);
    end
    @(negedge CLK);
    drv(LW, 32'h400, 32'h0, 1, 0, 1, 5'd11, 0);
    #1 chk("pri stall", 32'(Stall_OUT), 32'd1);
    chk("pri first drain", dm_addr, 32'h500);
    dm_ack = 1'b1;
    @(negedge CLK);
    dm_ack = 1'b0;
    chk("pri count", 32'(Sb_Count_OUT), 32'd2);
    @(negedge CLK);
    chk("pri load req", 32'(dm_req), 32'd1);
    chk("pri load we", 32'(dm_we), 32'd0);
    chk("pri load addr", dm_addr, 32'h400);
    dm_ack = 1'b1; dm_rdata = 32'hCAFE_F00D;
    @(negedge CLK);
    dm_ack = 1'b0;
    chk("pri wdata", WriteData_OUT, 32'hCAFE_F00D);
    idle_in();
    exp_q = '{32'h504, 32'h508};
    drain_all("pri fifo");

    // Fence: mem op stalls until buffer empty
    @(negedge CLK);
    drv(SW, 32'h900, 32'h55, 0, 1, 0, 5'd0, 0);
    @(negedge CLK);
    drv(SW, 32'h904, 32'h66, 0, 1, 0, 5'd0, 1);
    #1 chk("fence stall", 32'(Stall_OUT), 32'd1);
    @(negedge CLK);
    chk("fence drain addr", dm_addr, 32'h900);
    chk("fence stall drain", 32'(Stall_OUT), 32'd1);
    dm_ack = 1'b1;
    @(negedge CLK);
    dm_ack = 1'b0;
    chk("fence release", 32'(Stall_OUT), 32'd0);
    @(negedge CLK);
    chk("fence enq", 32'(Sb_Count_OUT), 32'd1);
    idle_in();
    exp_q = '{32'h904};
    drain_all("fence");

    // Reset while a load is outstanding with three buffered stores
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      drv(SW, 32'h700 + 32'(4 * i), 32'(i), 0, 1, 0, 5'd0, 0);
    end
    @(negedge CLK);
    drv(LW, 32'h800, 32'h0, 1, 0, 1, 5'd12, 0);
    dm_ack = 1'b1;
    @(negedge CLK);
    dm_ack = 1'b0;
    @(negedge CLK);
    chk("mid load req", 32'(dm_req), 32'd1);
    chk("mid count", 32'(Sb_Count_OUT), 32'd3);
    RESET = 1'b0;
    #1;
    chk("mid rst req", 32'(dm_req), 32'd0);
    chk("mid rst count", 32'(Sb_Count_OUT), 32'd0);
    chk("mid rst regwrite", 32'(RegWrite_OUT), 32'd0);
    chk("mid rst wdata", WriteData_OUT, 32'd0);
    @(negedge CLK);
    idle_in();
    RESET = 1'b1;
    @(negedge CLK);
    chk("post rst req", 32'(dm_req), 32'd0);
    chk("post rst count", 32'(Sb_Count_OUT), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
